// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MduWidth = 32;

  // Opcodes match the RV32M funct3 field.
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic {StIdle, StCalc} mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Radix-2 multiply/divide unit: shift-add multiply, restoring divide, WIDTH cycles per operation.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MduWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op_data1_i,
  input  logic [WIDTH-1:0] op_data2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  mdu_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   aux_q, aux_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic               is_div, rs1_signed, rs2_signed, neg1, neg2, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_trial, div_rem;
  logic               div_ge;
  logic [2*WIDTH:0]   step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_sel, final_res;

  // Operand decode and magnitude conversion at accept.
  always_comb begin
    is_div     = op_i[2];
    rs1_signed = (op_i == MDU_MULH) || (op_i == MDU_MULHSU) ||
                 (op_i == MDU_DIV) || (op_i == MDU_REM);
    rs2_signed = (op_i == MDU_MULH) || (op_i == MDU_DIV) || (op_i == MDU_REM);
    neg1       = rs1_signed & op_data1_i[WIDTH-1];
    neg2       = rs2_signed & op_data2_i[WIDTH-1];
    mag1       = neg1 ? -op_data1_i : op_data1_i;
    mag2       = neg2 ? -op_data2_i : op_data2_i;
    div_zero   = is_div && (op_data2_i == '0);
    div_ovf    = ((op_i == MDU_DIV) || (op_i == MDU_REM)) &&
                 (op_data1_i == MinNeg) && (op_data2_i == '1);
  end

  // One iteration step. acc_q holds {product hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, aux_q} : '0);
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, aux_q};
    div_rem   = div_ge ? div_trial - {1'b0, aux_q} : div_trial;
    if (op_q[2]) begin
      step = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end else begin
      step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    end
    prod_fix  = neg_q ? -step[2*WIDTH-1:0] : step[2*WIDTH-1:0];
    div_sel   = op_q[1] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    if (op_q[2]) begin
      final_res = neg_q ? -div_sel : div_sel;
    end else if (op_q == MDU_MUL) begin
      final_res = prod_fix[WIDTH-1:0];
    end else begin
      final_res = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    aux_d   = aux_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          op_d  = op_i;
          cnt_d = '0;
          neg_d = (is_div && op_i[1]) ? neg1 : (neg1 ^ neg2);
          if (div_zero) begin
            res_d   = op_i[1] ? op_data1_i : '1;
            valid_d = 1'b1;
          end else if (div_ovf) begin
            res_d   = op_i[1] ? '0 : op_data1_i;
            valid_d = 1'b1;
          end else begin
            state_d = StCalc;
            busy_d  = 1'b1;
            aux_d   = is_div ? mag2 : mag1;
            acc_d   = {{(WIDTH + 1){1'b0}}, (is_div ? mag1 : mag2)};
          end
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            res_d   = final_res;
            valid_d = 1'b1;
            state_d = StIdle;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      aux_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      aux_q   <= aux_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign res_o   = res_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized and directed checks of mdu against a plain-arithmetic RV32M model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [2:0]    op_i;
  logic [W-1:0]  op_data1_i, op_data2_i;
  logic          flush_i;
  logic          busy_o, valid_o;
  logic [W-1:0]  res_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  logic [W-1:0] last_res = '0;

  mdu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .op_data1_i (op_data1_i),
    .op_data2_i (op_data2_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .res_o      (res_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    up = {32'b0, a} * {32'b0, b};
    case (op)
      MDU_MUL:    begin p = sa * sb; return p[31:0]; end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_MULHU:  return up[63:32];
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Drive a request now; it is sampled on the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1; op_i = op; op_data1_i = a; op_data2_i = b;
    @(posedge clk); #1;
    t0 = cyc;
    start_i = 1'b0;
  endtask

  task automatic wait_result(input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input string tag);
    logic [W-1:0] exp;
    bit sp;
    int n;
    exp = ref_res(op, a, b);
    sp  = is_special(op, a, b);
    n   = 0;
    while (!valid_o && n < 200) begin
      chk({tag, "_busy"}, busy_o, !sp);
      @(posedge clk); #1;
      n++;
    end
    if (!valid_o) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_lat"}, cyc - t0, sp ? 0 : W);
      chk({tag, "_res"}, res_o, exp);
      chk({tag, "_busy_done"}, busy_o, 0);
      last_res = exp;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    @(negedge clk);
    issue(op, a, b);
    wait_result(op, a, b, tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, valid_o, 0);
  endtask

  initial begin
    int vh;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] corner [4];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; op_data1_i = '0; op_data2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_res", res_o, 0);
    @(negedge clk) rst = 1'b0;

    do_op(MDU_MUL, 32'd7, 32'hFFFF_FFFD, "mul");
    do_op(MDU_MULH, 32'h8000_0000, 32'h8000_0000, "mulh");
    do_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div");
    do_op(MDU_REM, 32'hFFFF_FFF9, 32'd2, "rem");
    do_op(MDU_DIVU, 32'd100, 32'd7, "divu");
    do_op(MDU_REMU, 32'd100, 32'd7, "remu");
    do_op(MDU_DIV, 32'd5, 32'd0, "div0");
    do_op(MDU_REMU, 32'd5, 32'd0, "remu0");
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Flush ten cycles into a divide: no result, previous result kept.
    @(negedge clk);
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", valid_o, 0);
    chk("flush_res", res_o, last_res);
    vh = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) vh++;
    end
    chk("flush_no_valid", vh, 0);

    // Start held during CALC is ignored.
    @(negedge clk);
    issue(MDU_MUL, 32'd123, 32'd456);
    start_i = 1'b1; op_i = MDU_DIVU; op_data1_i = 32'd9; op_data2_i = 32'd0;
    repeat (5) @(posedge clk);
    #1 start_i = 1'b0;
    wait_result(MDU_MUL, 32'd123, 32'd456, "held");
    @(posedge clk); #1;
    chk("held_pulse", valid_o, 0);

    // Back-to-back: start in the valid cycle.
    @(negedge clk);
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_result(MDU_DIVU, 32'd100, 32'd7, "b2b_a");
    issue(MDU_REMU, 32'd100, 32'd7);
    wait_result(MDU_REMU, 32'd100, 32'd7, "b2b_b");
    @(posedge clk); #1;
    chk("b2b_pulse", valid_o, 0);

    // Reset mid-MULHU.
    @(negedge clk);
    issue(MDU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_valid", valid_o, 0);
    chk("mrst_res", res_o, 0);
    @(negedge clk) rst = 1'b0;
    do_op(MDU_MUL, 32'd3, 32'd4, "after_rst");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      do_op(rop, ra, rb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
